// File: rtl/seq_control_unit_pkg.sv
// Shared definitions for the sequencing control unit: opcode classes, sequencer states,
// opcode constants and the opcode-field classifier used by the decoder.
package seq_cu_defs;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_LD   = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_ST   = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_JUMP = 4'b1100;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LD,
    CLS_LDI,
    CLS_ST,
    CLS_JC,
    CLS_JMP,
    CLS_NOP
  } op_class_e;

  typedef enum logic {
    EX1 = 1'b0,
    EX2 = 1'b1
  } seq_state_e;

  // Lowest bit of the opcode-class field; the Jc/JMP discriminator sits just below it.
  function automatic int opc_lsb(input int ir_w);
    return ir_w - OPC_W;
  endfunction

  function automatic op_class_e classify(input logic [OPC_W-1:0] opc, input logic jmp_bit);
    op_class_e cls;
    if (!opc[OPC_W-1]) begin
      cls = CLS_ALU;
    end else begin
      case (opc)
        OPC_LD:   cls = CLS_LD;
        OPC_LDI:  cls = CLS_LDI;
        OPC_ST:   cls = CLS_ST;
        OPC_JUMP: cls = jmp_bit ? CLS_JMP : CLS_JC;
        default:  cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// Bundle between the control unit (master: drives the datapath strobes) and the
// datapath/memory side (slave: supplies IR, flags and memory ready).
interface seq_control_unit_if #(
  parameter int REG_SEL_W  = 2,
  parameter int FLAG_SEL_W = 2,
  parameter int IR_W       = 8
);
  localparam int REG_CNT   = 2 ** REG_SEL_W;
  localparam int NUM_FLAGS = 2 ** FLAG_SEL_W;

  logic [IR_W-1:0]      ir;
  logic [NUM_FLAGS-1:0] flags;
  logic                 mem_rdy;

  logic                 mem_oe;
  logic                 mem_we;
  logic                 d_to_di_oe;
  logic                 ir_we;
  logic                 ip_inc;
  logic                 addr_dp;
  logic                 swap_p;
  logic [REG_CNT-1:0]   we_reg;
  logic [REG_CNT-1:0]   oe_reg_alu;
  logic                 oe_a_d;
  logic                 oe_b_d;
  logic                 we_flags;
  logic                 alu_oe;
  logic                 alu_invert;
  logic                 stall;

  modport master (
    input  ir, flags, mem_rdy,
    output mem_oe, mem_we, d_to_di_oe, ir_we, ip_inc, addr_dp, swap_p,
           we_reg, oe_reg_alu, oe_a_d, oe_b_d, we_flags, alu_oe, alu_invert, stall
  );

  modport slave (
    output ir, flags, mem_rdy,
    input  mem_oe, mem_we, d_to_di_oe, ir_we, ip_inc, addr_dp, swap_p,
           we_reg, oe_reg_alu, oe_a_d, oe_b_d, we_flags, alu_oe, alu_invert, stall
  );
endinterface

// File: rtl/seq_cu_decode.sv
// Pure combinational instruction decode: opcode class plus the register, flag,
// form and source select fields carried in the instruction LSBs.
module seq_cu_decode
  import seq_cu_defs::*;
#(
  parameter int REG_SEL_W  = 2,
  parameter int FLAG_SEL_W = 2,
  parameter int IR_W       = 8
) (
  input  logic [IR_W-1:0]       ir,
  output op_class_e             cls,
  output logic [REG_SEL_W-1:0]  dst,
  output logic                  alu_form,
  output logic                  st_src,
  output logic                  cond_pol,
  output logic [FLAG_SEL_W-1:0] flag_sel
);
  localparam int OPC_LO = opc_lsb(IR_W);

  assign cls      = classify(ir[IR_W-1:OPC_LO], ir[OPC_LO-1]);
  assign dst      = ir[REG_SEL_W-1:0];
  assign alu_form = ir[REG_SEL_W];
  assign st_src   = ir[0];
  assign cond_pol = ir[FLAG_SEL_W];
  assign flag_sel = ir[FLAG_SEL_W-1:0];
endmodule

// File: rtl/seq_control_unit.sv
// Two-state instruction sequencer driving the datapath strobes from IR and flags.
// Define SEQ_CU_WAIT_EN to honour mem_rdy (memory wait states, live stall output).
module seq_control_unit
  import seq_cu_defs::*;
#(
  parameter int REG_SEL_W  = 2,
  parameter int FLAG_SEL_W = 2,
  parameter int IR_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  seq_control_unit_if.master  bus
);
  localparam int REG_CNT = 2 ** REG_SEL_W;

  seq_state_e            state_q, state_d;
  op_class_e             cls;
  logic [REG_SEL_W-1:0]  dst;
  logic                  alu_form, st_src, cond_pol;
  logic [FLAG_SEL_W-1:0] flag_sel;

  logic                  mem_oe_c, mem_we_c, d_to_di_oe_c, ir_we_c, ip_inc_c;
  logic                  addr_dp_c, swap_p_c, oe_a_d_c, oe_b_d_c;
  logic                  we_flags_c, alu_oe_c, alu_invert_c, stall_c, fetch;
  logic [REG_CNT-1:0]    we_reg_c, oe_reg_alu_c;

  seq_cu_decode #(
    .REG_SEL_W (REG_SEL_W),
    .FLAG_SEL_W(FLAG_SEL_W),
    .IR_W      (IR_W)
  ) u_decode (
    .ir      (bus.ir),
    .cls     (cls),
    .dst     (dst),
    .alu_form(alu_form),
    .st_src  (st_src),
    .cond_pol(cond_pol),
    .flag_sel(flag_sel)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EX1;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    state_d      = state_q;
    fetch        = 1'b0;
    mem_oe_c     = 1'b1;
    mem_we_c     = 1'b1;
    d_to_di_oe_c = 1'b1;
    ir_we_c      = 1'b1;
    ip_inc_c     = 1'b1;
    addr_dp_c    = 1'b0;
    swap_p_c     = 1'b0;
    we_reg_c     = '1;
    oe_reg_alu_c = '1;
    oe_a_d_c     = 1'b1;
    oe_b_d_c     = 1'b1;
    we_flags_c   = 1'b1;
    alu_oe_c     = 1'b1;
    alu_invert_c = 1'b0;

    case (state_q)
      EX1: begin
        case (cls)
          CLS_ALU: begin
            fetch              = 1'b1;
            we_flags_c         = 1'b0;
            alu_oe_c           = 1'b0;
            oe_reg_alu_c[dst]  = 1'b0;
            if (alu_form) begin
              // Form 1 swaps the operands and always lands the result in A.
              alu_invert_c = 1'b1;
              we_reg_c[0]  = 1'b0;
            end else begin
              we_reg_c[dst] = 1'b0;
            end
          end
          CLS_LD: begin
            fetch         = 1'b1;
            addr_dp_c     = 1'b1;
            mem_oe_c      = 1'b0;
            d_to_di_oe_c  = 1'b0;
            we_reg_c[dst] = 1'b0;
          end
          CLS_LDI: state_d = EX2;
          CLS_ST: begin
            addr_dp_c = 1'b1;
            mem_we_c  = 1'b0;
            if (st_src) oe_b_d_c = 1'b0;
            else        oe_a_d_c = 1'b0;
            state_d   = EX2;
          end
          CLS_JC: begin
            fetch    = 1'b1;
            swap_p_c = bus.flags[flag_sel] ^ cond_pol;
          end
          CLS_JMP: begin
            fetch    = 1'b1;
            swap_p_c = 1'b1;
          end
          default: fetch = 1'b1;
        endcase
      end
      default: begin
        // EX2: LDI takes its immediate from [IP]; both LDI and ST fetch the next opcode.
        fetch   = 1'b1;
        state_d = EX1;
        if (cls == CLS_LDI) begin
          d_to_di_oe_c  = 1'b0;
          we_reg_c[dst] = 1'b0;
        end
      end
    endcase

    if (fetch) begin
      ir_we_c  = 1'b0;
      ip_inc_c = 1'b0;
      mem_oe_c = 1'b0;
    end

`ifdef SEQ_CU_WAIT_EN
    stall_c = (!mem_oe_c || !mem_we_c) && !bus.mem_rdy;
`else
    stall_c = 1'b0;
`endif

    // A stretched memory cycle keeps address/enables but commits nothing.
    if (stall_c) begin
      state_d    = state_q;
      ir_we_c    = 1'b1;
      ip_inc_c   = 1'b1;
      we_reg_c   = '1;
      we_flags_c = 1'b1;
      swap_p_c   = 1'b0;
    end

    // Reset is asynchronous on the outputs too, so the datapath sees idle strobes at once.
    if (!rst) begin
      mem_oe_c     = 1'b1;
      mem_we_c     = 1'b1;
      d_to_di_oe_c = 1'b1;
      ir_we_c      = 1'b1;
      ip_inc_c     = 1'b1;
      addr_dp_c    = 1'b0;
      swap_p_c     = 1'b0;
      we_reg_c     = '1;
      oe_reg_alu_c = '1;
      oe_a_d_c     = 1'b1;
      oe_b_d_c     = 1'b1;
      we_flags_c   = 1'b1;
      alu_oe_c     = 1'b1;
      alu_invert_c = 1'b0;
      stall_c      = 1'b0;
    end
  end

  assign bus.mem_oe     = mem_oe_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.d_to_di_oe = d_to_di_oe_c;
  assign bus.ir_we      = ir_we_c;
  assign bus.ip_inc     = ip_inc_c;
  assign bus.addr_dp    = addr_dp_c;
  assign bus.swap_p     = swap_p_c;
  assign bus.we_reg     = we_reg_c;
  assign bus.oe_reg_alu = oe_reg_alu_c;
  assign bus.oe_a_d     = oe_a_d_c;
  assign bus.oe_b_d     = oe_b_d_c;
  assign bus.we_flags   = we_flags_c;
  assign bus.alu_oe     = alu_oe_c;
  assign bus.alu_invert = alu_invert_c;
  assign bus.stall      = stall_c;
endmodule

// File: tb/tb_seq_control_unit.sv
// Randomised and directed bench for seq_control_unit against a cycle-level reference
// model of the instruction set; works with and without SEQ_CU_WAIT_EN.
module tb_seq_control_unit;

`ifdef SEQ_CU_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       mem_oe, mem_we, d_to_di_oe, ir_we, ip_inc, addr_dp, swap_p;
    logic [3:0] we_reg, oe_reg_alu;
    logic       oe_a_d, oe_b_d, we_flags, alu_oe, alu_invert, stall;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   second = 1'b0;  // model: 1 while the instruction is in its second cycle
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_control_unit_if #(.REG_SEL_W(2), .FLAG_SEL_W(2), .IR_W(8)) bus ();

  seq_control_unit #(.REG_SEL_W(2), .FLAG_SEL_W(2), .IR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t idle_outs();
    outs_t o;
    o = '0;
    o.mem_oe = 1; o.mem_we = 1; o.d_to_di_oe = 1; o.ir_we = 1; o.ip_inc = 1;
    o.we_reg = 4'hF; o.oe_reg_alu = 4'hF;
    o.oe_a_d = 1; o.oe_b_d = 1; o.we_flags = 1; o.alu_oe = 1;
    return o;
  endfunction

  // Expected strobes for one cycle, from the instruction-set description.
  function automatic outs_t model(input logic [7:0] i, input logic [3:0] f,
                                  input logic rdy, input bit sec);
    outs_t o;
    int top, top5, d;
    bit do_fetch;
    o = idle_outs();
    top = int'(i) / 16;
    top5 = int'(i) / 8;
    d = int'(i) % 4;
    do_fetch = 1'b1;
    if (sec) begin
      if (top == 10) begin
        o.d_to_di_oe = 0;
        o.we_reg = ~(4'b0001 << d);
      end
    end else if (top < 8) begin
      o.alu_oe = 0;
      o.we_flags = 0;
      o.oe_reg_alu = ~(4'b0001 << d);
      if (i[2]) begin
        o.alu_invert = 1;
        o.we_reg = 4'b1110;
      end else begin
        o.we_reg = ~(4'b0001 << d);
      end
    end else if (top == 8) begin
      o.addr_dp = 1; o.d_to_di_oe = 0;
      o.we_reg = ~(4'b0001 << d);
    end else if (top == 10) begin
      do_fetch = 1'b0;
    end else if (top == 11) begin
      do_fetch = 1'b0;
      o.addr_dp = 1; o.mem_we = 0;
      if (i[0]) o.oe_b_d = 0;
      else      o.oe_a_d = 0;
    end else if (top5 == 24) begin
      o.swap_p = f[d] ^ i[2];
    end else if (top5 == 25) begin
      o.swap_p = 1;
    end
    if (do_fetch) begin
      o.ir_we = 0; o.ip_inc = 0; o.mem_oe = 0;
    end
    if (WAIT_EN && !rdy && (!o.mem_oe || !o.mem_we)) begin
      o.stall = 1; o.ir_we = 1; o.ip_inc = 1; o.we_reg = 4'hF; o.we_flags = 1; o.swap_p = 0;
    end
    return o;
  endfunction

  function automatic bit model_next(input logic [7:0] i, input logic [3:0] f,
                                    input logic rdy, input bit sec);
    outs_t o;
    o = model(i, f, rdy, sec);
    if (o.stall) return sec;
    if (sec) return 1'b0;
    return (int'(i) / 16 == 10) || (int'(i) / 16 == 11);
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.mem_oe = bus.mem_oe; o.mem_we = bus.mem_we; o.d_to_di_oe = bus.d_to_di_oe;
    o.ir_we = bus.ir_we; o.ip_inc = bus.ip_inc; o.addr_dp = bus.addr_dp;
    o.swap_p = bus.swap_p; o.we_reg = bus.we_reg; o.oe_reg_alu = bus.oe_reg_alu;
    o.oe_a_d = bus.oe_a_d; o.oe_b_d = bus.oe_b_d; o.we_flags = bus.we_flags;
    o.alu_oe = bus.alu_oe; o.alu_invert = bus.alu_invert; o.stall = bus.stall;
    return o;
  endfunction

  task automatic set_in(input logic [7:0] i, input logic [3:0] f, input logic r);
    bus.ir = i;
    bus.flags = f;
    bus.mem_rdy = r;
  endtask

  // Advance one clock; the model steps only while reset is released.
  task automatic tick();
    bit nxt;
    nxt = model_next(bus.ir, bus.flags, bus.mem_rdy, second);
    @(posedge clk);
    second = rst ? nxt : 1'b0;
    #1;
  endtask

  task automatic test_reset();
    outs_t got, want;
    rst = 0;
    set_in(8'hB1, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    got = observe(); want = idle_outs(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL reset_idle: got %h want %h", got, want); end
    bus.ir = 8'h82;
    #1;
    got = observe(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL reset_idle_ld: got %h want %h", got, want); end
    @(posedge clk); #1;
    rst = 1; second = 0;
    set_in(8'h05, 4'h0, 1'b1);
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL first_cycle: got %h want %h", got, want); end
    n_tests++;
    if (got.ir_we !== 1'b0) begin n_fail++; $display("FAIL first_fetch ir_we: got %b want 0", got.ir_we); end
    tick();
  endtask

  task automatic test_ld();
    outs_t got, want;
    set_in(8'h82, 4'h0, 1'b1);
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ld: got %h want %h", got, want); end
    n_tests++;
    if (got.we_reg !== 4'b1011 || got.addr_dp !== 1'b1 || got.ir_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_fields: we_reg %b addr_dp %b ir_we %b want 1011 1 0", got.we_reg, got.addr_dp, got.ir_we);
    end
    tick();
  endtask

  task automatic test_ldi();
    outs_t got, want;
    set_in(8'hA1, 4'h0, 1'b1);
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ldi_ex1: got %h want %h", got, want); end
    n_tests++;
    if (got.ir_we !== 1'b1) begin n_fail++; $display("FAIL ldi_ex1 ir_we: got %b want 1", got.ir_we); end
    tick();
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL ldi_ex2: got %h want %h", got, want); end
    n_tests++;
    if (got.we_reg !== 4'b1101 || got.ip_inc !== 1'b0 || got.ir_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ldi_ex2_fields: we_reg %b ip_inc %b ir_we %b want 1101 0 0", got.we_reg, got.ip_inc, got.ir_we);
    end
    tick();
  endtask

  task automatic test_st_stall();
    outs_t got, want;
    int we_cycles, stall_cycles;
    we_cycles = 0; stall_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      set_in(8'hB1, 4'h0, (k == 3));
      @(negedge clk);
      got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL st_cycle%0d: got %h want %h", k, got, want); end
      if (got.mem_we === 1'b0) we_cycles++;
      if (got.stall === 1'b1) stall_cycles++;
      if (got.mem_we === 1'b0) begin
        n_tests++;
        if (got.oe_b_d !== 1'b0) begin n_fail++; $display("FAIL st_oe_b_d: got %b want 0", got.oe_b_d); end
      end
      tick();
    end
    n_tests++;
    if (we_cycles != (WAIT_EN ? 4 : 2)) begin
      n_fail++; $display("FAIL st_we_cycles: got %0d want %0d", we_cycles, WAIT_EN ? 4 : 2);
    end
    n_tests++;
    if (stall_cycles != (WAIT_EN ? 3 : 0)) begin
      n_fail++; $display("FAIL st_stall_cycles: got %0d want %0d", stall_cycles, WAIT_EN ? 3 : 0);
    end
    set_in(8'hB1, 4'h0, 1'b1);
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL st_after: got %h want %h", got, want); end
    tick();
    for (int k = 0; k < 2 && second; k++) begin
      set_in(8'h00, 4'h0, 1'b1);
      @(negedge clk);
      got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL st_flush: got %h want %h", got, want); end
      tick();
    end
  endtask

  task automatic test_jump();
    outs_t got, want;
    logic [7:0] irs [3] = '{8'hC6, 8'hC6, 8'hC8};
    logic [3:0] fls [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic       sw  [3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      set_in(irs[k], fls[k], 1'b1);
      @(negedge clk);
      got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL jump%0d: got %h want %h", k, got, want); end
      n_tests++;
      if (got.swap_p !== sw[k]) begin n_fail++; $display("FAIL jump%0d swap_p: got %b want %b", k, got.swap_p, sw[k]); end
      tick();
    end
  endtask

  task automatic test_alu_rdy_low();
    outs_t got, want;
    set_in(8'h05, 4'h0, 1'b0);
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL alu_rdy0: got %h want %h", got, want); end
    n_tests++;
    if (got.alu_invert !== 1'b1 || got.stall !== WAIT_EN || got.we_reg[0] !== WAIT_EN) begin
      n_fail++;
      $display("FAIL alu_rdy0_fields: alu_invert %b stall %b we_reg0 %b want 1 %b %b",
               got.alu_invert, got.stall, got.we_reg[0], WAIT_EN, WAIT_EN);
    end
    tick();
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL alu_rdy1: got %h want %h", got, want); end
    n_tests++;
    if (got.we_reg[0] !== 1'b0 || got.we_flags !== 1'b0 || got.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_rdy1_fields: we_reg0 %b we_flags %b stall %b want 0 0 0", got.we_reg[0], got.we_flags, got.stall);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    outs_t got, want;
    set_in(8'hB1, 4'h0, 1'b1);
    @(negedge clk);
    tick();
    @(negedge clk); #1;
    rst = 0;
    #1;
    got = observe(); n_tests++;
    if (got.mem_we !== 1'b1 || got.ir_we !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ex2: mem_we %b ir_we %b want 1 1", got.mem_we, got.ir_we);
    end
    want = idle_outs(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid_ex2_idle: got %h want %h", got, want); end
    tick();
    rst = 1;
    set_in(8'h00, 4'h0, 1'b1);
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want || got.ir_we !== 1'b0) begin n_fail++; $display("FAIL rst_release_fetch: got %h want %h", got, want); end
    tick();
    set_in(8'h82, 4'h0, 1'b0);
    @(negedge clk); #1;
    rst = 0;
    #1;
    got = observe(); want = idle_outs(); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid_stall: got %h want %h", got, want); end
    tick();
    rst = 1;
    bus.mem_rdy = 1'b1;
    @(negedge clk);
    got = observe(); want = model(bus.ir, bus.flags, bus.mem_rdy, second); n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL rst_stall_release: got %h want %h", got, want); end
    tick();
  endtask

  task automatic test_random();
    outs_t got, want;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) != 0);
      set_in(8'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
      @(negedge clk);
      got = observe();
      want = rst ? model(bus.ir, bus.flags, bus.mem_rdy, second) : idle_outs();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random%0d ir=%h flags=%h rdy=%b: got %h want %h", k, bus.ir, bus.flags, bus.mem_rdy, got, want);
      end
      tick();
    end
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_ld();
    test_ldi();
    test_st_stall();
    test_jump();
    test_alu_rdy_low();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
